// File: rtl/ball_pkg.sv
// Shared definitions for the ball motion block: FSM states and default playfield geometry.
package ball_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    UPDATE,
    COLLIDE,
    MISS
  } ball_state_e;

  localparam int unsigned POS_W     = 9;
  localparam int unsigned BALL_SIZE = 4;
  localparam int unsigned H_LIMIT   = 256;
  localparam int unsigned V_LIMIT   = 240;
  localparam int unsigned HOME_H    = 128;
  localparam int unsigned HOME_V    = 128;

endpackage

// File: rtl/vsync_tick.sv
// Rising-edge detector turning the vsync level into a single-clock frame tick.
module vsync_tick (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vsync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vsync_q <= 1'b0;
    end else begin
      r_vsync_q <= i_vsync;
    end
  end

  assign o_tick = i_vsync & ~r_vsync_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion FSM: serve, move, wall/paddle bounce and miss recovery.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int unsigned SPEED       = 2,
  parameter int unsigned MISS_FRAMES = 60
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vsync,
  input  logic             i_serve,
  input  logic             i_paddle_hit,
  output logic [POS_W-1:0] o_ball_hpos,
  output logic [POS_W-1:0] o_ball_vpos,
  output logic             o_ball_active,
  output logic             o_miss
);

  localparam int unsigned CntW = $clog2(MISS_FRAMES + 1);
  localparam logic [POS_W-1:0] Spd    = POS_W'(SPEED);
  localparam logic [POS_W-1:0] HBound = POS_W'(H_LIMIT - BALL_SIZE);
  localparam logic [POS_W-1:0] VBound = POS_W'(V_LIMIT - BALL_SIZE);
  localparam logic [POS_W-1:0] HomeH  = POS_W'(HOME_H);
  localparam logic [POS_W-1:0] HomeV  = POS_W'(HOME_V);
  localparam logic [CntW-1:0]  MissLast = CntW'(MISS_FRAMES - 1);

  logic w_tick;

  vsync_tick u_vsync_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_vsync (i_vsync),
    .o_tick  (w_tick)
  );

  ball_state_e      r_state, w_state_nxt;
  logic [POS_W-1:0] r_hpos, w_hpos_nxt;
  logic [POS_W-1:0] r_vpos, w_vpos_nxt;
  logic             r_dir_right, w_dir_right_nxt;
  logic             r_dir_down, w_dir_down_nxt;
  logic             r_hit, w_hit_nxt;
  logic [CntW-1:0]  r_miss_cnt, w_miss_cnt_nxt;
  logic             r_miss, w_miss_nxt;
  logic             w_hit_now;

  // A paddle hit in the COLLIDE cycle itself still counts toward the bounce.
  assign w_hit_now = r_hit | i_paddle_hit;

  always_comb begin
    w_state_nxt     = r_state;
    w_hpos_nxt      = r_hpos;
    w_vpos_nxt      = r_vpos;
    w_dir_right_nxt = r_dir_right;
    w_dir_down_nxt  = r_dir_down;
    w_hit_nxt       = w_hit_now;
    w_miss_cnt_nxt  = r_miss_cnt;
    w_miss_nxt      = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_hpos_nxt = HomeH;
        w_vpos_nxt = HomeV;
        if (w_tick && i_serve) begin
          w_state_nxt     = MOVE;
          w_dir_right_nxt = 1'b0;
          w_dir_down_nxt  = 1'b1;
        end
      end
      MOVE: begin
        if (w_tick) w_state_nxt = UPDATE;
      end
      UPDATE: begin
        w_hpos_nxt  = r_dir_right ? (r_hpos + Spd) : (r_hpos - Spd);
        w_vpos_nxt  = r_dir_down  ? (r_vpos + Spd) : (r_vpos - Spd);
        w_state_nxt = COLLIDE;
      end
      COLLIDE: begin
        w_hit_nxt   = 1'b0;
        w_state_nxt = MOVE;
        // Flips are qualified by current direction so a ball past a wall cannot oscillate.
        if (r_dir_down && (r_vpos >= VBound)) begin
          w_dir_down_nxt = 1'b0;
        end else if (!r_dir_down && (r_vpos < Spd)) begin
          w_dir_down_nxt = 1'b1;
        end
        if (r_dir_right && (r_hpos >= HBound)) begin
          w_dir_right_nxt = 1'b0;
        end else if (!r_dir_right && w_hit_now) begin
          w_dir_right_nxt = 1'b1;
        end else if (!r_dir_right && (r_hpos < Spd)) begin
          w_state_nxt = MISS;
          w_miss_nxt  = 1'b1;
        end
      end
      MISS: begin
        if (w_tick) begin
          if (r_miss_cnt == MissLast) begin
            w_state_nxt     = IDLE;
            w_hpos_nxt      = HomeH;
            w_vpos_nxt      = HomeV;
            w_dir_right_nxt = 1'b0;
            w_dir_down_nxt  = 1'b1;
            w_miss_cnt_nxt  = '0;
          end else begin
            w_miss_cnt_nxt = r_miss_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_hpos      <= HomeH;
      r_vpos      <= HomeV;
      r_dir_right <= 1'b0;
      r_dir_down  <= 1'b1;
      r_hit       <= 1'b0;
      r_miss_cnt  <= '0;
      r_miss      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hpos      <= w_hpos_nxt;
      r_vpos      <= w_vpos_nxt;
      r_dir_right <= w_dir_right_nxt;
      r_dir_down  <= w_dir_down_nxt;
      r_hit       <= w_hit_nxt;
      r_miss_cnt  <= w_miss_cnt_nxt;
      r_miss      <= w_miss_nxt;
    end
  end

  assign o_ball_hpos   = r_hpos;
  assign o_ball_vpos   = r_vpos;
  assign o_ball_active = (r_state == MOVE) || (r_state == UPDATE) || (r_state == COLLIDE);
  assign o_miss        = r_miss;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: serve, wall bounces, miss recovery, paddle hits, reset.
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset, vsync, serve, paddle_hit;
  logic [8:0] hpos, vpos;
  logic       active, miss;

  int n_pass = 0;
  int n_total = 0;
  int n_miss_pulses = 0;

  ball_motion_ctrl dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_vsync      (vsync),
    .i_serve      (serve),
    .i_paddle_hit (paddle_hit),
    .o_ball_hpos  (hpos),
    .o_ball_vpos  (vpos),
    .o_ball_active(active),
    .o_miss       (miss)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (miss === 1'b1) n_miss_pulses++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One full frame: vsync pulse then idle time; returns on a negedge.
  task automatic frame();
    @(negedge clk) vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick_tail();
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; serve = 1'b0; paddle_hit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_h", int'(hpos), 128);
    chk("rst_v", int'(vpos), 128);
    chk("rst_active", int'(active), 0);
    chk("rst_miss", int'(miss), 0);
    reset = 1'b0;

    // Serve and check UPDATE latency on the first motion tick.
    serve = 1'b1;
    frame();
    serve = 1'b0;
    chk("serve_active", int'(active), 1);
    @(negedge clk) vsync = 1'b1;
    @(posedge clk); #1;
    chk("upd_pre_h", int'(hpos), 128);
    @(posedge clk); #1;
    chk("upd_lat_h", int'(hpos), 126);
    chk("upd_lat_v", int'(vpos), 130);
    tick_tail();

    for (int i = 2; i <= 54; i++) frame();
    chk("t54_v", int'(vpos), 236);
    chk("t54_h", int'(hpos), 20);
    frame();
    chk("t55_v", int'(vpos), 234);
    frame();
    chk("t56_v", int'(vpos), 232);
    for (int i = 57; i <= 63; i++) frame();
    chk("t63_h", int'(hpos), 2);

    // Tick 64 with no paddle: miss.
    @(negedge clk) vsync = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t64_h", int'(hpos), 0);
    @(posedge clk); #1;
    chk("miss_pulse", int'(miss), 1);
    chk("miss_inactive", int'(active), 0);
    @(posedge clk); #1;
    chk("miss_one_cycle", int'(miss), 0);
    tick_tail();
    chk("miss_count1", n_miss_pulses, 1);
    for (int i = 1; i <= 59; i++) frame();
    chk("miss59_h", int'(hpos), 0);
    chk("miss59_v", int'(vpos), 216);
    frame();
    chk("miss60_h", int'(hpos), 128);
    chk("miss60_v", int'(vpos), 128);
    chk("miss60_active", int'(active), 0);

    // Paddle save at the left edge.
    serve = 1'b1;
    frame();
    serve = 1'b0;
    for (int i = 1; i <= 63; i++) frame();
    paddle_hit = 1'b1;
    @(negedge clk) paddle_hit = 1'b0;
    frame();
    chk("save_h", int'(hpos), 0);
    chk("save_active", int'(active), 1);
    chk("save_no_miss", n_miss_pulses, 1);
    frame();
    chk("t65_h", int'(hpos), 2);
    for (int i = 66; i <= 172; i++) frame();
    chk("t172_v", int'(vpos), 0);
    chk("t172_h", int'(hpos), 216);
    frame();
    chk("t173_v", int'(vpos), 2);
    for (int i = 174; i <= 179; i++) frame();

    // Paddle held across a whole frame while moving right: no effect.
    paddle_hit = 1'b1;
    frame();
    paddle_hit = 1'b0;
    chk("t180_h", int'(hpos), 232);
    frame();
    chk("t181_h", int'(hpos), 234);
    for (int i = 182; i <= 190; i++) frame();
    chk("t190_h", int'(hpos), 252);
    frame();
    chk("t191_h", int'(hpos), 250);
    for (int i = 192; i <= 194; i++) frame();

    // Paddle only in the COLLIDE cycle while moving left: flip.
    @(negedge clk) vsync = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    paddle_hit = 1'b1;
    @(posedge clk); #1;
    paddle_hit = 1'b0;
    tick_tail();
    chk("t195_h", int'(hpos), 242);
    frame();
    chk("t196_h", int'(hpos), 244);
    chk("t196_v", int'(vpos), 48);

    // Reset in MOVE.
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rmove_h", int'(hpos), 128);
    chk("rmove_v", int'(vpos), 128);
    chk("rmove_active", int'(active), 0);
    chk("rmove_miss", int'(miss), 0);

    // Serve together with reset stays idle.
    serve = 1'b1;
    frame();
    reset = 1'b0;
    serve = 1'b0;
    chk("srst_active", int'(active), 0);
    frame();
    chk("idle_hold_active", int'(active), 0);
    chk("idle_hold_h", int'(hpos), 128);

    // Reset in MISS.
    serve = 1'b1;
    frame();
    serve = 1'b0;
    for (int i = 1; i <= 64; i++) frame();
    chk("rmiss_pre_h", int'(hpos), 0);
    chk("miss_count2", n_miss_pulses, 2);
    for (int i = 1; i <= 5; i++) frame();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rmiss_h", int'(hpos), 128);
    chk("rmiss_v", int'(vpos), 128);
    chk("rmiss_miss", int'(miss), 0);
    chk("rmiss_active", int'(active), 0);
    @(negedge clk) reset = 1'b0;
    frame();
    chk("rmiss_idle_active", int'(active), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
Per-frame motion controller for the single playfield ball. It sequences serve, move, wall/paddle bounce and miss recovery, and drives ball_hpos/ball_vpos to the pixel-compare logic in the top level. Everything is clocked by clk: vsync is sampled as a level and edge-detected, never used as a clock. Direction flips are edge-qualified by current direction, so a ball sitting past a boundary cannot oscillate.

Parameters:
BALL_SIZE, 4, ball edge in pixels
H_LIMIT, 256, visible width; right-wall bounce at H_LIMIT-BALL_SIZE
V_LIMIT, 240, visible height; bottom-wall bounce at V_LIMIT-BALL_SIZE
SPEED, 2, pixels moved per frame per axis (1..7)
HOME_H, 128, serve/idle horizontal position
HOME_V, 128, serve/idle vertical position
MISS_FRAMES, 60, frames held in MISS before returning to IDLE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vsync  in  1  vertical sync from hvsync_generator (level; rising edge = frame tick)
serve  in  1  launch request, sampled on frame tick while IDLE
paddle_hit  in  1  paddle/ball overlap from the collision compare (any cycle)
ball_hpos  out  9  ball left edge, registered
ball_vpos  out  9  ball top edge, registered
ball_active  out  1  1 in MOVE/UPDATE/COLLIDE; gates ball graphics
miss  out  1  one-cycle pulse on entry to MISS

Behaviour:
- Reset (sync, wins over every other input): state=IDLE, ball_hpos=HOME_H, ball_vpos=HOME_V, dir_h=left, dir_v=down, hit_flag=0, miss_cnt=0, ball_active=0, miss=0, vsync_q=0.
- frame_tick = vsync & ~vsync_q, where vsync_q is vsync registered once. frame_tick is high for exactly one clk.
- hit_flag is set by paddle_hit in any cycle. It is cleared on the cycle the FSM leaves COLLIDE. If paddle_hit is high in the COLLIDE cycle itself, it counts toward that cycle's evaluation.
- IDLE: position is held at home and ball_active=0. On frame_tick with serve=1, go to MOVE with dir_h=left and dir_v=down. serve is ignored outside IDLE.
- MOVE: on frame_tick, go to UPDATE.
- UPDATE (1 cycle): hpos += SPEED (right) or -= SPEED (left); vpos likewise. Arithmetic is 9-bit modulo. Outputs change 1 clk after frame_tick. Go to COLLIDE.
- COLLIDE (1 cycle) evaluates the updated position. Priority per axis:
  - V axis: if dir_v=down and vpos >= V_LIMIT-BALL_SIZE, set dir_v=up. If dir_v=up and vpos < SPEED, set dir_v=down.
  - H axis, first match wins:
    1. dir_h=right and hpos >= H_LIMIT-BALL_SIZE: set dir_h=left.
    2. dir_h=left and (hit_flag or paddle_hit): set dir_h=right.
    3. dir_h=left and hpos < SPEED: go to MISS.
  - Otherwise return to MOVE.
  - Direction registers update 2 clk after frame_tick; new motion applies on the next frame.
- MISS: miss=1 in the entry cycle only; ball_active=0; miss_cnt counts frame_ticks. When miss_cnt reaches MISS_FRAMES: hpos=HOME_H, vpos=HOME_V, dir_h=left, dir_v=down, miss_cnt=0, go to IDLE.
- A frame_tick arriving while in UPDATE or COLLIDE is ignored (it cannot occur at real frame rates).
- Reset mid-operation returns to the reset state on the next clk edge, including during MISS.

Decomposition:
- Package ball_pkg holds:
  - state enum {IDLE, MOVE, UPDATE, COLLIDE, MISS}
  - default geometry constants: BALL_SIZE, H_LIMIT, V_LIMIT, HOME_H, HOME_V
  - POS_W=9
- One sub-module: vsync_tick, a rising-edge detector producing frame_tick. It is reused later by the paddle and score blocks.

Test Plan:
- Reset, then serve=1 across first frame_tick -> ball_active=1. After the next tick: hpos=126, vpos=130; UPDATE latency is exactly 1 clk.
- Free run after serve -> vpos reaches 236 on tick 54, dir_v flips, tick 55 gives vpos=234. No double flip at 236/234.
- No paddle_hit, left travel -> tick 64 gives hpos=0 and a one-cycle miss pulse, ball_active=0. 60 further ticks -> IDLE with hpos=128, vpos=128.
- paddle_hit pulse for 1 clk between ticks 63 and 64 -> at tick 64 hpos=0, dir_h flips right, no miss. Tick 65 gives hpos=2. Rightward travel reaches 252 and flips left.
- paddle_hit held high through COLLIDE while dir_h=right -> no effect. paddle_hit in the COLLIDE cycle with dir_h=left -> flip.
- reset asserted mid-MOVE and mid-MISS -> next clk: IDLE, hpos=128, vpos=128, miss=0, ball_active=0. Simultaneous serve+reset -> stays IDLE.
